// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for U_FIFO: sequences the wrst pulse after reset/flush and
// grants the shared write port round-robin between two producers in bounded bursts.
module fifo_wr_arbiter #(
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              flush,
    input  logic              full_flag,
    output logic              wrst,
    output logic              we,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1
);

    typedef enum logic [1:0] {FLUSH, IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] RST_LEN    = 8'(RST_CYCLES);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state_reg, state_next;
    logic       wrst_reg, wrst_next;
    logic [7:0] rst_cnt_reg, rst_cnt_next;
    logic [7:0] burst_reg, burst_next;
    logic       last_grant_reg, last_grant_next;
    logic       flush_pend_reg, flush_pend_next;

    logic [1:0] req;
    logic [1:0] ack;
    logic       grant_valid;
    logic       grant_idx;

    assign req         = {req1, req0};
    assign grant_valid = (state_reg == GNT0) || (state_reg == GNT1);
    assign grant_idx   = (state_reg == GNT1);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [15:0] cnt_reg;

            assign ack[gi] = grant_valid && (grant_idx == 1'(gi)) && req[gi] && !full_flag;

            // Saturating so a long soak never wraps back to a misleading small count.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    cnt_reg <= '0;
                end else if (ack[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign ack0    = ack[0];
    assign ack1    = ack[1];
    assign we      = |ack;
    assign wr_data = grant_valid ? (grant_idx ? data1 : data0) : '0;
    assign busy    = (state_reg != IDLE);
    assign wrst    = wrst_reg;
    assign cnt0    = g_req[0].cnt_reg;
    assign cnt1    = g_req[1].cnt_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= FLUSH;
            wrst_reg       <= 1'b1;
            rst_cnt_reg    <= '0;
            burst_reg      <= '0;
            last_grant_reg <= 1'b1;
            flush_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wrst_reg       <= wrst_next;
            rst_cnt_reg    <= rst_cnt_next;
            burst_reg      <= burst_next;
            last_grant_reg <= last_grant_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wrst_next       = wrst_reg;
        rst_cnt_next    = rst_cnt_reg;
        burst_next      = burst_reg;
        last_grant_next = last_grant_reg;
        flush_pend_next = flush_pend_reg;

        case (state_reg)
            FLUSH: begin
                if (rst_cnt_reg == RST_LEN) begin
                    state_next   = IDLE;
                    wrst_next    = 1'b0;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 8'd1;
                end
            end
            IDLE: begin
                // Entry edge already counts as the first wrst cycle, hence the preload of 1.
                if (flush || flush_pend_reg) begin
                    state_next      = FLUSH;
                    wrst_next       = 1'b1;
                    rst_cnt_next    = 8'd1;
                    flush_pend_next = 1'b0;
                end else if (req[0] && (!req[1] || last_grant_reg)) begin
                    state_next = GNT0;
                end else if (req[1]) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (flush) begin
                    flush_pend_next = 1'b1;
                end
                if (ack[grant_idx]) begin
                    burst_next = burst_reg + 8'd1;
                end
                if (!req[grant_idx] || (ack[grant_idx] && (burst_reg == BURST_LAST))) begin
                    burst_next      = '0;
                    last_grant_next = grant_idx;
                    if (req[~grant_idx]) begin
                        state_next = grant_idx ? GNT0 : GNT1;
                    end else if (!req[grant_idx]) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = FLUSH;
                wrst_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then a random soak, every cycle
// checked against a grant/flush reference model kept in plain integers.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int DATA_W     = 8;
    localparam int MAX_BURST  = 16;
    localparam int RST_CYCLES = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              req0, req1, flush, full_flag;
    logic [DATA_W-1:0] data0, data1;
    logic              ack0, ack1, wrst, we, busy;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       cnt0, cnt1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .flush(flush), .full_flag(full_flag),
        .wrst(wrst), .we(we), .wr_data(wr_data), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // producers: a queue of words each; pendN means the head word is offered
    logic [7:0] q0[$], q1[$], wr_log[$];
    bit pend0, pend1, rnd_mode;
    int wrst_hi, we_hi;

    // reference model: flush cycles remaining, current owner (-1 none), words in burst
    int  m_rem, m_owner, m_taken, m_last;
    bit  m_pend;
    int  m_cnt[2];
    bit  e_ack0, e_ack1, e_we, e_wrst, e_busy;
    logic [7:0] e_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem   = RST_CYCLES + 1;
        m_owner = -1;
        m_taken = 0;
        m_last  = 1;
        m_pend  = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic model_expect();
        bit act;
        act    = (m_rem == 0);
        e_wrst = (m_rem > 0);
        e_busy = (m_rem > 0) || (m_owner >= 0);
        e_ack0 = act && (m_owner == 0) && req0 && !full_flag;
        e_ack1 = act && (m_owner == 1) && req1 && !full_flag;
        e_we   = e_ack0 || e_ack1;
        e_data = (act && m_owner == 0) ? data0 : (act && m_owner == 1) ? data1 : 8'h00;
    endtask

    task automatic model_edge();
        int i;
        bit ri, ro, ai;
        if (m_rem > 0) begin
            m_rem--;
        end else if (m_owner < 0) begin
            if (flush || m_pend) begin
                m_rem  = RST_CYCLES;
                m_pend = 0;
            end else if (req0 && req1) begin
                m_owner = 1 - m_last;
            end else if (req0) begin
                m_owner = 0;
            end else if (req1) begin
                m_owner = 1;
            end
        end else begin
            i  = m_owner;
            ri = (i == 1) ? req1 : req0;
            ro = (i == 1) ? req0 : req1;
            ai = (i == 1) ? e_ack1 : e_ack0;
            if (flush) m_pend = 1;
            if (ai) begin
                if (m_cnt[i] < 65535) m_cnt[i]++;
                m_taken++;
            end
            if (!ri || m_taken == MAX_BURST) begin
                m_taken = 0;
                m_last  = i;
                m_owner = ro ? 1 - i : (ri ? i : -1);
            end
        end
    endtask

    // one clock: drive at negedge, check before the edge, advance model after it
    task automatic cycle();
        if (rnd_mode) begin
            while (q0.size() < 2) q0.push_back(8'($urandom));
            while (q1.size() < 2) q1.push_back(8'($urandom));
        end
        if (!pend0) pend0 = (q0.size() > 0) && (!rnd_mode || $urandom_range(0, 1) == 0);
        if (!pend1) pend1 = (q1.size() > 0) && (!rnd_mode || $urandom_range(0, 1) == 0);
        req0  = pend0;
        data0 = pend0 ? q0[0] : 8'h00;
        req1  = pend1;
        data1 = pend1 ? q1[0] : 8'h00;
        #1;
        model_expect();
        check("ack0", 32'(ack0), 32'(e_ack0));
        check("ack1", 32'(ack1), 32'(e_ack1));
        check("we", 32'(we), 32'(e_we));
        check("wr_data", 32'(wr_data), 32'(e_data));
        check("wrst", 32'(wrst), 32'(e_wrst));
        check("busy", 32'(busy), 32'(e_busy));
        check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
        if (wrst) wrst_hi++;
        if (we) begin
            we_hi++;
            wr_log.push_back(wr_data);
        end
        @(posedge clk);
        #1;
        model_edge();
        if (e_ack0) begin
            void'(q0.pop_front());
            pend0 = (q0.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
        end
        if (e_ack1) begin
            void'(q1.pop_front());
            pend1 = (q1.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(m_rem == 0 && m_owner < 0) && n < 300) begin
            cycle();
            n++;
        end
        #1;
        check("idle_wait_busy", 32'(busy), 32'(0));
    endtask

    task automatic run_drain(input int limit);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < limit) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check("drain_left", 32'(q0.size() + q1.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cb0, cb1, n40;
        n_rst = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        flush = 0; full_flag = 0; pend0 = 0; pend1 = 0; rnd_mode = 0;
        wrst_hi = 0; we_hi = 0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_wrst", 32'(wrst), 32'(1));
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_we", 32'(we), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_cnt0", 32'(cnt0), 32'(0));
        check("rst_cnt1", 32'(cnt1), 32'(0));
        @(negedge clk);
        n_rst = 1'b1;

        // boot write-reset sequence
        cycle();
        wrst_hi = 0; we_hi = 0;
        repeat (8) cycle();
        check("boot_wrst_len", 32'(wrst_hi), 32'(RST_CYCLES));
        check("boot_no_we", 32'(we_hi), 32'(0));

        // single requester, 20 words across a burst boundary
        wr_log.delete();
        for (int k = 0; k < 20; k++) q0.push_back(8'(k));
        repeat (26) cycle();
        check("solo_cnt0", 32'(cnt0), 32'(20));
        check("solo_log_len", 32'(wr_log.size()), 32'(20));
        for (int k = 0; k < 20 && k < wr_log.size(); k++) check("solo_log", 32'(wr_log[k]), 32'(k));

        // both requesters saturated: alternating 16-word bursts
        wait_idle();
        cb0 = cnt0; cb1 = cnt1;
        for (int k = 0; k < 32; k++) begin
            q0.push_back(8'(8'h20 + k));
            q1.push_back(8'(8'h80 + k));
        end
        run_drain(200);
        check("dual_cnt0", 32'(cnt0), 32'(cb0 + 32));
        check("dual_cnt1", 32'(cnt1), 32'(cb1 + 32));

        // full_flag stall mid-burst with the other requester waiting
        wait_idle();
        wr_log.delete();
        for (int k = 0; k < 20; k++) q0.push_back(8'(8'h40 + k));
        for (int k = 0; k < 30; k++) begin
            if (k == 3) begin
                for (int j = 0; j < 10; j++) q1.push_back(8'(8'hA0 + j));
            end
            full_flag = (k >= 6 && k < 11);
            if (k == 6) we_hi = 0;
            cycle();
            if (k == 10) check("full_we_blocked", 32'(we_hi), 32'(0));
        end
        full_flag = 0;
        run_drain(100);
        n40 = 0;
        for (int k = 0; k < 16 && k < wr_log.size(); k++)
            if (wr_log[k] >= 8'h40 && wr_log[k] < 8'h50) n40++;
        check("full_burst_owner0", 32'(n40), 32'(16));

        // flush pulse during a grant: deferred until IDLE, then a full wrst pulse
        wait_idle();
        cb0 = cnt0; cb1 = cnt1;
        for (int k = 0; k < 5; k++) q1.push_back(8'(8'hC0 + k));
        for (int k = 0; k < 16; k++) begin
            flush = (k == 2);
            if (k == 3) wrst_hi = 0;
            cycle();
        end
        flush = 0;
        check("flush_wrst_len", 32'(wrst_hi), 32'(RST_CYCLES));
        check("flush_cnt0", 32'(cnt0), 32'(cb0));
        check("flush_cnt1", 32'(cnt1), 32'(cb1 + 5));

        // asynchronous reset in the middle of a burst
        wait_idle();
        for (int k = 0; k < 10; k++) q0.push_back(8'(8'hE0 + k));
        repeat (5) cycle();
        req0 = 1'b1; data0 = q0[0];
        #1;
        check("prerst_we", 32'(we), 32'(1));
        #1;
        n_rst = 1'b0;
        #1;
        check("async_we", 32'(we), 32'(0));
        check("async_ack0", 32'(ack0), 32'(0));
        check("async_ack1", 32'(ack1), 32'(0));
        check("async_cnt0", 32'(cnt0), 32'(0));
        check("async_cnt1", 32'(cnt1), 32'(0));
        check("async_wrst", 32'(wrst), 32'(1));
        q0.delete(); q1.delete(); pend0 = 0; pend1 = 0;
        req0 = 0; req1 = 0;
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        cycle();
        wrst_hi = 0;
        repeat (8) cycle();
        check("reboot_wrst_len", 32'(wrst_hi), 32'(RST_CYCLES));

        // random soak
        rnd_mode = 1;
        for (int k = 0; k < 1500; k++) begin
            full_flag = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            cycle();
        end
        full_flag = 0; flush = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
